// File: rtl/matrix_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_wb_arbiter_if
// Two-master / one-slave pipelined Wishbone bundle around matrix_wb_arbiter.
// Revision : 1.0
// ============================================================================
interface matrix_wb_arbiter_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int REG_COUNT     = 8,
    parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
);
    logic                     i_m0_cyc;
    logic                     i_m0_stb;
    logic                     i_m0_we;
    logic [WB_ADDR_WIDTH-1:0] i_m0_addr;
    logic [WB_SEL_WIDTH-1:0]  i_m0_sel;
    logic [WB_DATA_WIDTH-1:0] i_m0_wdata;
    logic                     o_m0_ack;
    logic                     o_m0_stall;
    logic [WB_DATA_WIDTH-1:0] o_m0_rdata;

    logic                     i_m1_cyc;
    logic                     i_m1_stb;
    logic                     i_m1_we;
    logic [WB_ADDR_WIDTH-1:0] i_m1_addr;
    logic [WB_SEL_WIDTH-1:0]  i_m1_sel;
    logic [WB_DATA_WIDTH-1:0] i_m1_wdata;
    logic                     o_m1_ack;
    logic                     o_m1_stall;
    logic [WB_DATA_WIDTH-1:0] o_m1_rdata;

    logic                     o_s_cyc;
    logic                     o_s_stb;
    logic                     o_s_we;
    logic [WB_ADDR_WIDTH-1:0] o_s_addr;
    logic [WB_SEL_WIDTH-1:0]  o_s_sel;
    logic [WB_DATA_WIDTH-1:0] o_s_wdata;
    logic                     i_s_ack;
    logic                     i_s_stall;
    logic [WB_DATA_WIDTH-1:0] i_s_rdata;

    logic [1:0]               o_grant;

    // master: the arbiter itself (it masters the shared slave); slave: everything around it
    modport master (
        input  i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_sel, i_m0_wdata,
        output o_m0_ack, o_m0_stall, o_m0_rdata,
        input  i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_sel, i_m1_wdata,
        output o_m1_ack, o_m1_stall, o_m1_rdata,
        output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_sel, o_s_wdata,
        input  i_s_ack, i_s_stall, i_s_rdata,
        output o_grant
    );

    modport slave (
        output i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_sel, i_m0_wdata,
        input  o_m0_ack, o_m0_stall, o_m0_rdata,
        output i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_sel, i_m1_wdata,
        input  o_m1_ack, o_m1_stall, o_m1_rdata,
        input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_sel, o_s_wdata,
        output i_s_ack, i_s_stall, i_s_rdata,
        input  o_grant
    );
endinterface
`default_nettype wire

// File: rtl/matrix_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : matrix_wb_arbiter
// Two-master pipelined Wishbone arbiter for the 8x8 matrix row-register slave.
// Option   : MATRIX_ARB_ROUND_ROBIN_EN selects alternating tie-break in IDLE.
// Revision : 1.0
// ============================================================================
module matrix_wb_arbiter #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    matrix_wb_arbiter_if.master   bus
);
    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN0  = 2'd1;
    localparam logic [1:0] S_OWN1  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_owner_q, last_owner_d;

    logic full_w;
    logic stall_eff_w;
    logic accept_w;
    logic ack_dec_w;
    logic tie_to_m1_w;

    assign full_w      = (cnt_q == CNT_MAX);
    assign stall_eff_w = bus.i_s_stall | full_w;
    assign accept_w    = bus.o_s_cyc & bus.o_s_stb & ~stall_eff_w;
    assign ack_dec_w   = bus.i_s_ack & (cnt_q != '0);

`ifdef MATRIX_ARB_ROUND_ROBIN_EN
    assign tie_to_m1_w = ~last_owner_q;
`else
    assign tie_to_m1_w = 1'b0;
`endif

    // Strobe is withheld from the slave while the window is full so a beat the
    // owner sees as stalled can never be taken by the slave.
    always_comb begin
        bus.o_s_cyc    = 1'b0;
        bus.o_s_stb    = 1'b0;
        bus.o_s_we     = 1'b0;
        bus.o_s_addr   = '0;
        bus.o_s_sel    = '0;
        bus.o_s_wdata  = '0;
        bus.o_m0_ack   = 1'b0;
        bus.o_m0_stall = 1'b1;
        bus.o_m0_rdata = '0;
        bus.o_m1_ack   = 1'b0;
        bus.o_m1_stall = 1'b1;
        bus.o_m1_rdata = '0;
        bus.o_grant    = 2'b00;
        case (state_q)
            S_OWN0: begin
                bus.o_s_cyc    = bus.i_m0_cyc;
                bus.o_s_stb    = bus.i_m0_stb & ~full_w;
                bus.o_s_we     = bus.i_m0_we;
                bus.o_s_addr   = bus.i_m0_addr;
                bus.o_s_sel    = bus.i_m0_sel;
                bus.o_s_wdata  = bus.i_m0_wdata;
                bus.o_m0_stall = stall_eff_w;
                bus.o_m0_ack   = bus.i_s_ack;
                bus.o_m0_rdata = bus.i_s_rdata;
                bus.o_grant    = 2'b01;
            end
            S_OWN1: begin
                bus.o_s_cyc    = bus.i_m1_cyc;
                bus.o_s_stb    = bus.i_m1_stb & ~full_w;
                bus.o_s_we     = bus.i_m1_we;
                bus.o_s_addr   = bus.i_m1_addr;
                bus.o_s_sel    = bus.i_m1_sel;
                bus.o_s_wdata  = bus.i_m1_wdata;
                bus.o_m1_stall = stall_eff_w;
                bus.o_m1_ack   = bus.i_s_ack;
                bus.o_m1_rdata = bus.i_s_rdata;
                bus.o_grant    = 2'b10;
            end
            S_DRAIN: begin
                if (last_owner_q) begin
                    bus.o_m1_ack   = bus.i_s_ack;
                    bus.o_m1_rdata = bus.i_s_rdata;
                end else begin
                    bus.o_m0_ack   = bus.i_s_ack;
                    bus.o_m0_rdata = bus.i_s_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept_w && !ack_dec_w) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!accept_w && ack_dec_w) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Owners always hand over through IDLE; there is no OWN0 <-> OWN1 arc.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_m0_cyc && (!bus.i_m1_cyc || !tie_to_m1_w)) begin
                    state_d      = S_OWN0;
                    last_owner_d = 1'b0;
                end else if (bus.i_m1_cyc) begin
                    state_d      = S_OWN1;
                    last_owner_d = 1'b1;
                end
            end
            S_OWN0: begin
                if (!bus.i_m0_cyc) begin
                    state_d = (cnt_d == '0) ? S_IDLE : S_DRAIN;
                end
            end
            S_OWN1: begin
                if (!bus.i_m1_cyc) begin
                    state_d = (cnt_d == '0) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_matrix_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_wb_arbiter
// Self-checking bench for matrix_wb_arbiter: vector table plus scoreboarded bursts.
// Revision : 1.0
// ============================================================================
module tb_matrix_wb_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    matrix_wb_arbiter_if #(.WB_DATA_WIDTH(32), .REG_COUNT(8)) bus ();

    matrix_wb_arbiter #(.MAX_OUTSTANDING(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_stall, s_ack}
    // out = {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack}
    typedef struct {
        logic [5:0] in;
        logic [1:0] grant;
        logic [5:0] out;
        logic [2:0] addr;
    } vec_t;

    vec_t        vt[13];
    logic [34:0] mq[$];
    logic [31:0] rq[$];
    logic [31:0] pend[$];
    int          ackq[$];
    int          tie_exp[3];

    function automatic vec_t mk(input logic [5:0] in, input logic [1:0] g,
                                input logic [5:0] o, input logic [2:0] a);
        vec_t v;
        v.in = in; v.grant = g; v.out = o; v.addr = a;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_m0_cyc = 1'b0; bus.i_m0_stb = 1'b0; bus.i_m0_we = 1'b0;
        bus.i_m0_addr = '0;  bus.i_m0_sel = '0;   bus.i_m0_wdata = '0;
        bus.i_m1_cyc = 1'b0; bus.i_m1_stb = 1'b0; bus.i_m1_we = 1'b0;
        bus.i_m1_addr = '0;  bus.i_m1_sel = '0;   bus.i_m1_wdata = '0;
        bus.i_s_ack = 1'b0;  bus.i_s_stall = 1'b0; bus.i_s_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int beat, acks0, acks1, first_g, m1_leak, spurious, sbeats;
        int first_m1, drain_acks, drain_leak, acc, bp_bad, w;
        logic        ack_next;
        logic [31:0] rd_next;

        vt[0]  = mk(6'b000000, 2'b00, 6'b001100, 3'd0);
        vt[1]  = mk(6'b100000, 2'b00, 6'b001100, 3'd0);
        vt[2]  = mk(6'b110000, 2'b01, 6'b110100, 3'd3);
        vt[3]  = mk(6'b110011, 2'b01, 6'b111110, 3'd3);
        vt[4]  = mk(6'b111100, 2'b01, 6'b110100, 3'd3);
        vt[5]  = mk(6'b001100, 2'b01, 6'b000100, 3'd3);
        vt[6]  = mk(6'b001101, 2'b00, 6'b001110, 3'd0);
        vt[7]  = mk(6'b001100, 2'b00, 6'b001100, 3'd0);
        vt[8]  = mk(6'b001101, 2'b10, 6'b111001, 3'd5);
        vt[9]  = mk(6'b001001, 2'b10, 6'b101001, 3'd5);
        vt[10] = mk(6'b100000, 2'b10, 6'b001000, 3'd5);
        vt[11] = mk(6'b101000, 2'b00, 6'b001100, 3'd0);
        vt[12] = mk(6'b101000, 2'b01, 6'b100100, 3'd3);
`ifdef MATRIX_ARB_ROUND_ROBIN_EN
        tie_exp[0] = 0; tie_exp[1] = 1; tie_exp[2] = 0;
`else
        tie_exp[0] = 0; tie_exp[1] = 0; tie_exp[2] = 0;
`endif

        // Reset state with a pending request and a stray slave ack
        idle_inputs();
        reset_n = 1'b0;
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_s_ack = 1'b1;
        #3;
        check("rst_grant", bus.o_grant, 2'b00);
        check("rst_s_cyc_stb", {bus.o_s_cyc, bus.o_s_stb, bus.o_s_we}, 3'b000);
        check("rst_stalls", {bus.o_m0_stall, bus.o_m1_stall}, 2'b11);
        check("rst_acks", {bus.o_m0_ack, bus.o_m1_ack}, 2'b00);
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.i_s_ack = 1'b0;
        next_cycle();
        #2 check("rst_first_grant", bus.o_grant, 2'b01);

        // Vector table
        do_reset();
        bus.i_m0_addr = 3'd3; bus.i_m0_wdata = 32'h1111_0000; bus.i_m0_sel = 4'hF;
        bus.i_m1_addr = 3'd5; bus.i_m1_wdata = 32'h2222_0000; bus.i_m1_sel = 4'h3;
        bus.i_s_rdata = 32'h5A5A_0000;
        for (int i = 0; i < 13; i++) begin
            {bus.i_m0_cyc, bus.i_m0_stb, bus.i_m1_cyc, bus.i_m1_stb,
             bus.i_s_stall, bus.i_s_ack} = vt[i].in;
            #2;
            check($sformatf("vec%0d", i),
                  {bus.o_grant, bus.o_s_cyc, bus.o_s_stb, bus.o_m0_stall, bus.o_m1_stall,
                   bus.o_m0_ack, bus.o_m1_ack, bus.o_s_addr},
                  {vt[i].grant, vt[i].out, vt[i].addr});
            next_cycle();
        end

        // Single-master 8-beat burst, slave acks one cycle after accept
        do_reset();
        beat = 0; acks0 = 0; acks1 = 0; first_g = -1; m1_leak = 0; spurious = 0; sbeats = 0;
        ack_next = 1'b0; rd_next = '0;
        mq.delete(); rq.delete();
        for (int c = 0; c < 40 && !(beat == 8 && acks0 == 8); c++) begin
            bus.i_m0_cyc = 1'b1; bus.i_m0_stb = (beat < 8); bus.i_m0_we = 1'b1;
            bus.i_m0_addr = beat[2:0]; bus.i_m0_wdata = 32'hC0DE_0000 + beat; bus.i_m0_sel = 4'hF;
            bus.i_s_stall = 1'b0; bus.i_s_ack = ack_next; bus.i_s_rdata = rd_next;
            #2;
            if (first_g < 0 && bus.o_grant == 2'b01) first_g = c;
            if (bus.o_m1_stall !== 1'b1 || bus.o_m1_ack !== 1'b0) m1_leak++;
            if (bus.o_m0_ack) begin
                acks0++;
                if (rq.size() > 0) check("burst_rdata", bus.o_m0_rdata, rq.pop_front());
                else spurious++;
            end
            if (bus.o_m1_ack) acks1++;
            if (bus.i_m0_stb && !bus.o_m0_stall) begin
                mq.push_back({bus.i_m0_addr, bus.i_m0_wdata});
                beat++;
            end
            if (bus.o_s_cyc && bus.o_s_stb && !bus.i_s_stall) begin
                sbeats++;
                if (mq.size() > 0) check("burst_slave_beat", {bus.o_s_addr, bus.o_s_wdata}, mq.pop_front());
                else spurious++;
                ack_next = 1'b1;
                rd_next  = 32'hD00D_0000 | 32'(bus.o_s_addr);
                rq.push_back(rd_next);
            end else begin
                ack_next = 1'b0;
            end
            next_cycle();
        end
        check("burst_first_grant_cycle", first_g, 1);
        check("burst_slave_beats", sbeats, 8);
        check("burst_m0_acks", acks0, 8);
        check("burst_m1_acks", acks1, 0);
        check("burst_m1_stall_held", m1_leak, 0);
        check("burst_spurious", spurious, 0);

        // Tie contests
        do_reset();
        bus.i_m0_cyc = 1'b1; bus.i_m1_cyc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = -1;
            for (int t = 0; t < 5 && w < 0; t++) begin
                #2;
                if (bus.o_grant == 2'b01) w = 0;
                else if (bus.o_grant == 2'b10) w = 1;
                next_cycle();
            end
            check($sformatf("tie_winner%0d", k), w, tie_exp[k]);
            if (w == 0) bus.i_m0_cyc = 1'b0;
            if (w == 1) bus.i_m1_cyc = 1'b0;
            next_cycle();
            bus.i_m0_cyc = 1'b1; bus.i_m1_cyc = 1'b1;
        end

        // Drain: m0 issues 3 beats, acks arrive 4 cycles later, m1 waiting
        do_reset();
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b0; bus.i_m1_addr = 3'd6;
        beat = 0; acks0 = 0; acks1 = 0; first_m1 = -1; drain_acks = 0; drain_leak = 0;
        ackq.delete(); pend.delete(); rq.delete();
        for (int c = 0; c < 30 && first_m1 < 0; c++) begin
            bus.i_m0_cyc = (beat < 3); bus.i_m0_stb = (beat < 3);
            bus.i_m0_addr = beat[2:0]; bus.i_m0_wdata = 32'hAA00_0000 + beat;
            bus.i_s_stall = 1'b0;
            if (ackq.size() > 0 && ackq[0] == c) begin
                void'(ackq.pop_front());
                bus.i_s_ack = 1'b1;
                bus.i_s_rdata = pend.pop_front();
                rq.push_back(bus.i_s_rdata);
            end else begin
                bus.i_s_ack = 1'b0;
                bus.i_s_rdata = '0;
            end
            #2;
            if (bus.o_m0_ack) begin
                acks0++;
                if (rq.size() > 0) check("drain_rdata", bus.o_m0_rdata, rq.pop_front());
            end
            if (bus.o_m1_ack) acks1++;
            if (bus.o_grant == 2'b00 && bus.o_m0_ack) drain_acks++;
            if (bus.o_grant == 2'b00 && bus.o_s_cyc) drain_leak++;
            if (bus.o_grant == 2'b10) first_m1 = c;
            if (bus.i_m0_stb && !bus.o_m0_stall) begin
                beat++;
                ackq.push_back(c + 4);
                pend.push_back(32'hBEEF_0000 + beat);
            end
            next_cycle();
        end
        check("drain_m0_acks", acks0, 3);
        check("drain_m1_acks", acks1, 0);
        check("drain_acks_while_ungranted", drain_acks, 3);
        check("drain_s_cyc_low", drain_leak, 0);
        check("drain_m1_grant_cycle", first_m1, 9);

        // Backpressure and outstanding-limit stall
        do_reset();
        bus.i_m0_cyc = 1'b1; bus.i_m0_stb = 1'b1; bus.i_m0_we = 1'b1;
        acc = 0; bp_bad = 0;
        for (int c = 0; c < 18; c++) begin
            bus.i_s_stall = (c >= 3 && c <= 7);
            bus.i_s_ack   = (c == 16);
            bus.i_s_rdata = 32'h0000_BEAD;
            bus.i_m0_addr = acc[2:0];
            #2;
            if (c >= 3 && c <= 7 && bus.o_m0_stall !== 1'b1) bp_bad++;
            if (c == 14) check("bp_full_stall_a", bus.o_m0_stall, 1'b1);
            if (c == 15) check("bp_full_stall_b", bus.o_m0_stall, 1'b1);
            if (c == 16) check("bp_ack_at_full", {bus.o_m0_stall, bus.o_m0_ack}, 2'b11);
            if (c == 17) check("bp_release", bus.o_m0_stall, 1'b0);
            if (bus.i_m0_stb && !bus.o_m0_stall) acc++;
            if (c == 7)  check("bp_count_hold", acc, 2);
            if (c == 13) check("bp_reach_max", acc, 8);
            if (c == 16) check("bp_no_accept_at_max", acc, 8);
            next_cycle();
        end
        check("bp_stall_follows_slave", bp_bad, 0);

        // Asynchronous reset mid-burst while m1 owns the bus
        do_reset();
        bus.i_m1_cyc = 1'b1; bus.i_m1_stb = 1'b1; bus.i_m1_addr = 3'd2;
        next_cycle();
        bus.i_s_ack = 1'b1;
        #2 check("ar_grant_before", {bus.o_grant, bus.o_m1_ack}, 3'b101);
        #1 reset_n = 1'b0;
        #1 check("ar_async_outputs",
                 {bus.o_grant, bus.o_s_cyc, bus.o_s_stb, bus.o_m0_stall, bus.o_m1_stall,
                  bus.o_m0_ack, bus.o_m1_ack},
                 8'b00_0_0_1_1_0_0);
        bus.i_s_ack = 1'b0;
        @(posedge clk);
        #2 check("ar_held", bus.o_grant, 2'b00);
        reset_n = 1'b1;
        @(posedge clk);
        #2 check("ar_first_edge_grant", bus.o_grant, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
